// File: rtl/expipe_pkg.sv
// Execution-pipe types for the multiplier unit: opcode encoding and stage record.
package expipe_pkg;

  localparam int unsigned MULT_CTL_LEN  = 4;
  localparam int unsigned MULT_RS_DEPTH = 4;
  localparam int unsigned MULT_IDX_W    = $clog2(MULT_RS_DEPTH);

  typedef enum logic [MULT_CTL_LEN-1:0] {
    MULT_MUL    = 4'd0,
    MULT_MULW   = 4'd1,
    MULT_MULH   = 4'd2,
    MULT_MULHU  = 4'd3,
    MULT_MULHSU = 4'd4
  } mult_ctl_t;

  // Stage record widths follow the core defaults above.
  typedef struct packed {
    logic                      valid;
    logic [len5_pkg::XLEN-1:0] result;
    logic [MULT_IDX_W-1:0]     entry_idx;
    logic                      except_raised;
    logic                      fused;
  } mult_stage_t;

endpackage

// File: rtl/len5_pkg.sv
// Core-wide widths and exception codes shared by the len5 backend units.
package len5_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [3:0] {
    E_INSTR_ADDR_MISALIGNED = 4'h0,
    E_INSTR_ACCESS_FAULT    = 4'h1,
    E_ILLEGAL_INSTRUCTION   = 4'h2
  } except_code_t;

endpackage

// File: rtl/mult_pipelined_if.sv
// Issue/result handshake between the multiplier RS, the multiplier and the CDB arbiter.
interface mult_pipelined_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned CTL_LEN = 4
);
  import len5_pkg::*;

  logic               valid_i;
  logic               ready_o;
  logic [CTL_LEN-1:0] ctl_i;
  logic [IDX_W-1:0]   entry_idx_i;
  logic [XLEN-1:0]    rs1_value_i;
  logic [XLEN-1:0]    rs2_value_i;

  logic               valid_o;
  logic               ready_i;
  logic [IDX_W-1:0]   entry_idx_o;
  logic [XLEN-1:0]    result_o;
  logic               fused_o;
  logic               except_raised_o;
  except_code_t       except_code_o;

  modport slave (
    input  valid_i, ctl_i, entry_idx_i, rs1_value_i, rs2_value_i, ready_i,
    output ready_o, valid_o, entry_idx_o, result_o, fused_o, except_raised_o, except_code_o
  );

  modport master (
    output valid_i, ctl_i, entry_idx_i, rs1_value_i, rs2_value_i, ready_i,
    input  ready_o, valid_o, entry_idx_o, result_o, fused_o, except_raised_o, except_code_o
  );

endinterface

// File: rtl/mult_op_cache.sv
// Single-entry MULH->MUL fusion cache: remembers operands and the low product half.
module mult_op_cache #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_rs1,
  input  logic [XLEN-1:0] wr_rs2,
  input  logic [XLEN-1:0] wr_low,
  input  logic [XLEN-1:0] rd_rs1,
  input  logic [XLEN-1:0] rd_rs2,
  output logic            hit,
  output logic [XLEN-1:0] hit_low
);

  logic            valid;
  logic [XLEN-1:0] tag_rs1;
  logic [XLEN-1:0] tag_rs2;
  logic [XLEN-1:0] low;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid   <= 1'b0;
      tag_rs1 <= '0;
      tag_rs2 <= '0;
      low     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid   <= 1'b1;
      tag_rs1 <= wr_rs1;
      tag_rs2 <= wr_rs2;
      low     <= wr_low;
    end
  end

  // Lookup sees pre-edge contents, so a same-cycle write never self-hits.
  assign hit     = valid && (tag_rs1 == rd_rs1) && (tag_rs2 == rd_rs2);
  assign hit_low = low;

endmodule

// File: rtl/mult_pipelined.sv
// Fully pipelined RV64M multiplier: combinational product at issue, PIPE_DEPTH
// valid-tracked stages with whole-pipe stall, flush, and MULH->MUL fusion.
module mult_pipelined
  import len5_pkg::*;
  import expipe_pkg::*;
#(
  parameter int unsigned XLEN       = len5_pkg::XLEN,
  parameter int unsigned RS_DEPTH   = 4,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned EU_CTL_LEN = 4
) (
  input logic               clk_i,
  input logic               rst_n_i,
  input logic               flush_i,
  mult_pipelined_if.slave   bus
);

  localparam int unsigned HALF = XLEN / 2;

  mult_ctl_t         ctl;
  logic              adv;
  logic              accept;
  logic              sign_a;
  logic              sign_b;
  logic              is_high;
  logic [2*XLEN-1:0] op_a;
  logic [2*XLEN-1:0] op_b;
  logic [2*XLEN-1:0] prod;
  logic [HALF-1:0]   prod_w;
  logic              hit;
  logic [XLEN-1:0]   hit_low;
  logic [XLEN-1:0]   res;
  logic              exc;
  logic              fused;

  mult_stage_t stage [PIPE_DEPTH];

  assign ctl    = mult_ctl_t'(bus.ctl_i);
  assign adv    = !stage[PIPE_DEPTH-1].valid || bus.ready_i;
  assign accept = bus.valid_i && adv && !flush_i;

  assign bus.ready_o = adv;

  // One double-width multiplier serves MUL and all high variants via operand extension.
  assign sign_a  = (ctl == MULT_MULH) || (ctl == MULT_MULHSU);
  assign sign_b  = (ctl == MULT_MULH);
  assign is_high = (ctl == MULT_MULH) || (ctl == MULT_MULHU) || (ctl == MULT_MULHSU);
  assign op_a    = {{XLEN{sign_a & bus.rs1_value_i[XLEN-1]}}, bus.rs1_value_i};
  assign op_b    = {{XLEN{sign_b & bus.rs2_value_i[XLEN-1]}}, bus.rs2_value_i};
  assign prod    = op_a * op_b;
  assign prod_w  = bus.rs1_value_i[HALF-1:0] * bus.rs2_value_i[HALF-1:0];

  mult_op_cache #(.XLEN(XLEN)) u_cache (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush   (flush_i),
    .wr_en   (accept && is_high),
    .wr_rs1  (bus.rs1_value_i),
    .wr_rs2  (bus.rs2_value_i),
    .wr_low  (prod[XLEN-1:0]),
    .rd_rs1  (bus.rs1_value_i),
    .rd_rs2  (bus.rs2_value_i),
    .hit     (hit),
    .hit_low (hit_low)
  );

  always_comb begin
    res   = '0;
    exc   = 1'b0;
    fused = 1'b0;
    case (ctl)
      MULT_MUL: begin
        if (hit) begin
          res   = hit_low;
          fused = 1'b1;
        end else begin
          res = prod[XLEN-1:0];
        end
      end
      MULT_MULW:   res = {{HALF{prod_w[HALF-1]}}, prod_w};
      MULT_MULH,
      MULT_MULHU,
      MULT_MULHSU: res = prod[2*XLEN-1:XLEN];
      default:     exc = 1'b1;
    endcase
  end

  for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stage
    if (s == 0) begin : g_first
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          stage[s] <= '0;
        end else if (flush_i) begin
          stage[s].valid <= 1'b0;
        end else if (adv) begin
          stage[s] <= '{valid: accept, result: res, entry_idx: bus.entry_idx_i,
                        except_raised: exc, fused: fused};
        end
      end
    end else begin : g_next
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          stage[s] <= '0;
        end else if (flush_i) begin
          stage[s].valid <= 1'b0;
        end else if (adv) begin
          stage[s] <= stage[s-1];
        end
      end
    end
  end

  assign bus.valid_o         = stage[PIPE_DEPTH-1].valid;
  assign bus.result_o        = stage[PIPE_DEPTH-1].result;
  assign bus.entry_idx_o     = stage[PIPE_DEPTH-1].entry_idx;
  assign bus.except_raised_o = stage[PIPE_DEPTH-1].except_raised;
  assign bus.fused_o         = stage[PIPE_DEPTH-1].fused;
  assign bus.except_code_o   = E_ILLEGAL_INSTRUCTION;

endmodule

// File: doc/mult_pipelined.md
# mult_pipelined

Parametrised, fully pipelined integer multiplier execution unit for the expipe backend. It sits between the multiplier reservation station and the common data bus arbiter. It accepts one RV64M multiply per cycle (MUL, MULW, MULH, MULHU, MULHSU) and returns results in order after a fixed latency. It supports valid-tracked pipeline stages, whole-pipe back-pressure, flush, and a MULH→MUL fusion cache.

## Interface
- XLEN, 64, operand/result width (even, ≥ 8)
- RS_DEPTH, 4, reservation-station depth (power of 2); entry index width = $clog2(RS_DEPTH)
- PIPE_DEPTH, 3, number of pipeline register stages (≥ 1)
- EU_CTL_LEN, 4, width of ctl_i
- Clock and reset: clk_i; reset rst_n_i, asynchronous, active-low.
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  squash all in-flight operations and invalidate the cache
- valid_i  in  1  operation present from the RS
- ready_o  out  1  unit can accept this cycle
- ctl_i  in  EU_CTL_LEN  operation code (mult_ctl_t)
- entry_idx_i  in  $clog2(RS_DEPTH)  RS entry tag
- rs1_value_i, rs2_value_i  in  XLEN  operands
- valid_o  out  1  result present
- ready_i  in  1  downstream accepts result
- entry_idx_o  out  $clog2(RS_DEPTH)  tag of the result
- result_o  out  XLEN  result
- fused_o  out  1  result was served from the fusion cache
- except_raised_o  out  1  illegal ctl_i
- except_code_o  out  except_code_t  constant E_ILLEGAL_INSTRUCTION

## Operation
- The arithmetic is computed combinationally at the input.
  - MUL: low XLEN bits of the product.
  - MULH: high XLEN bits of signed×signed.
  - MULHU: high XLEN bits of unsigned×unsigned.
  - MULHSU: high XLEN bits of signed rs1 × unsigned rs2.
  - MULW: product of the low XLEN/2 bits; low XLEN/2 bits of that product, sign-extended from bit XLEN/2-1.
- An unknown ctl_i is still accepted: result 0, except_raised 1, fused 0.
- Fusion cache (sub-module mult_op_cache) holds a valid bit, rs1, rs2 and the low XLEN bits of the product.
  - Writes: on any accepted MULH/MULHU/MULHSU. The low half is independent of signedness.
  - Hits: an accepted MUL hits when the cache is valid and both operands match. On a hit the cached low half is used and fused = 1.
- Pipeline: PIPE_DEPTH stages, each holding {valid, result, entry_idx, except_raised, fused}. Stage 1 captures the input; stage PIPE_DEPTH drives the outputs.
- Advance enable: adv = !valid_o || ready_i. When adv = 1 all stages shift. When adv = 0 all stages hold.
- ready_o = adv. This is a combinational path from ready_i, and is accepted.
- Accept condition: valid_i && ready_o && !flush_i.
- Flush: all stage valid bits and the cache valid bit clear on the next edge. An input presented in a flush cycle is dropped. Data fields need not clear.

## Timing
- Reset values: valid_o 0, result_o 0, entry_idx_o 0, except_raised_o 0, fused_o 0, all stage valids 0, cache invalid. ready_o is therefore 1 after reset.
- Latency: an operation accepted at edge t appears on valid_o after edge t+PIPE_DEPTH-1, i.e. PIPE_DEPTH cycles, with no stalls.
- Throughput: 1 operation per cycle.
- Results are returned strictly in acceptance order. Every stall adds exactly one cycle.
- Fusion window: a cache write from a MULH accepted at edge t is visible to a MUL accepted at edge t+1. Back-to-back MULH;MUL fuses.
- Simultaneous cache write and lookup: the lookup uses the pre-edge cache contents.
- Back-pressure: while valid_o && !ready_i, the outputs are held stable, ready_o = 0, and the cache is not written.
- Flush with valid_o && !ready_i: valid_o drops on the next edge; the pending result is discarded.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). No result is emitted.

## Structure
- expipe_pkg holds:
  - mult_ctl_t enum: MULT_MUL, MULT_MULW, MULT_MULH, MULT_MULHU, MULT_MULHSU
  - the pipeline stage struct mult_stage_t
- len5_pkg supplies XLEN defaults and except_code_t.
- One sub-module, mult_op_cache, owns the valid bit, the operand tags, the low-half register, and the hit compare.
- Stages are generated with a for-generate over a mult_stage_t array.

## Test plan
- MUL rs1=3, rs2=-2 (XLEN=64) -> result 0xFFFFFFFFFFFFFFFA, valid_o exactly PIPE_DEPTH cycles after accept.
- MULH -1 × -1 -> 0. The next-cycle MUL with the same operands -> 1, fused_o=1. A MUL with rs2=5 instead -> fused_o=0, result 0xFFFFFFFFFFFFFFFB.
- MULW 0x7FFFFFFF × 2 -> 0xFFFFFFFFFFFFFFFE. MULHU 0xFFFFFFFFFFFFFFFF × 2 -> 1. MULHSU -1 × 2 -> 0xFFFFFFFFFFFFFFFF.
- Stream of 6 ops with entry_idx 0..3,0,1 and ready_i low for 5 cycles mid-stream -> all 6 results, in order, none lost or duplicated. Outputs stable while stalled; ready_o low while stalled.
- flush_i with 3 ops in flight and a MULH cached -> valid_o 0 on the next cycle, no stale results. A following MUL on the same operands gives fused_o=0.
- ctl_i=0xF -> except_raised_o=1, result_o 0, except_code_o E_ILLEGAL_INSTRUCTION. Assert rst_n_i mid-stream -> all outputs 0 immediately.
